simon_round_engine: RTL
=======================

// Module: simon_round_engine
// PURPOSE
//  Iterative Simon128/256 encryption datapath; consumes the round keys produced by key_schedule.
//  Takes one 128-bit plaintext block, reads round keys 0..NUM_ROUNDS-1 over the key read port,
//  applies one Feistel round per key and returns the ciphertext block.
//  Sits between the data-side AXI adaptation and the key memory inside simon128_256_encrypt's datapath.
// PARAMETERS
//  WORD_WIDTH      64   Simon word size n; block = 2*WORD_WIDTH
//  NUM_ROUNDS      72   rounds (Simon128/256)
//  KEY_ADDR_WIDTH   9   width of key_addr
//  KEY_BASE         0   key memory address of round key 0
// PORTS
//  clk           in   1      clock; all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  key_mem_full  in   1      1 = key memory holds a complete round-key set
//  key_addr      out  9      round-key read address
//  key_rd_en     out  1      one-cycle read strobe
//  key_data      in   64     round key, valid when key_data_vld
//  key_data_vld  in   1      read-data valid (>=1 cycle after key_rd_en)
//  in_valid      in   1      plaintext block offered
//  in_ready      out  1      engine can accept a block
//  in_block      in   128    plaintext {x[127:64], y[63:0]}
//  out_valid     out  1      ciphertext available
//  out_ready     in   1      consumer accepts ciphertext
//  out_block     out  128    ciphertext {x, y}
//  key_abort     out  1      one-cycle pulse: operation dropped, key_mem_full fell mid-block
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, key_rd_en, key_abort = 0; key_addr=KEY_BASE; out_block=0; round=0.
//  FSM IDLE -> FETCH -> WAIT -> (FETCH | DONE) -> IDLE.
//   IDLE : in_ready = key_mem_full. in_valid&&in_ready: latch {x,y}, round=0, -> FETCH.
//   FETCH: key_rd_en=1 for exactly this cycle, key_addr=KEY_BASE+round (zero-extended) -> WAIT.
//   WAIT : key_rd_en=0; hold until key_data_vld. On vld: x<=y^f(x)^key_data, y<=x;
//          if round==NUM_ROUNDS-1 -> DONE else round++ and -> FETCH.
//   DONE : out_valid=1, out_block stable; on out_ready -> IDLE (out_valid=0 next cycle).
//  f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x), all mod 2^WORD_WIDTH; XORs are full-width, no carries.
//  in_ready is 0 in every state but IDLE; in_valid elsewhere is ignored (no buffering).
//  key_data_vld outside WAIT is ignored; key_data never sampled outside WAIT.
//  Latency (1-cycle key memory): accept at T -> first key_rd_en T+1 -> last round applied T+144
//   -> out_valid at T+145. Throughput 1 block / (2*NUM_ROUNDS+2) cycles with out_ready held high.
//  out_ready while out_valid=0 has no effect; same-cycle out_ready in DONE and in_valid: block not
//   accepted until IDLE (one bubble cycle).
//  key_mem_full low in FETCH or WAIT: abort -> IDLE next cycle, key_abort=1 for one cycle,
//   no out_valid, any later key_data_vld ignored. key_mem_full low in DONE: ciphertext still delivered.
//  rst mid-operation: immediate return to reset values; in-flight block discarded, no key_abort.
//  round counter 7 bits; never exceeds NUM_ROUNDS-1 (no wrap).
// STRUCTURE
//  simon_pkg: SIMON_WORD_W=64, SIMON_ROUNDS=72, SIMON_KEY_AW=9, typedef simon_word_t,
//   typedef struct {simon_word_t x, y;} simon_block_t, enum eng_state_t {IDLE,FETCH,WAIT,DONE},
//   function simon_f(simon_word_t).
//  Sub-module simon_round: combinational one-round (x,y,k -> x',y'); reused by a future decrypt engine.
//  Engine itself: FSM, round counter, x/y registers, key-port drive.
// TESTING
//  Key model fills round keys from key 1f1e..0100 (32 bytes), 1-cycle read latency; in_block
//   74206e69206d6f6f_6d69732061207369 -> out_block 8d2b5579afc8a3a0_3bf72a87efe7b868, out_valid at T+145.
//  Random key read latency 1..5 cycles per read -> same ciphertext; exactly 72 key_rd_en pulses,
//   addresses 0..71 in order, never two strobes without an intervening vld.
//  key_mem_full=0 with in_valid=1 for 20 cycles -> in_ready=0, no key_rd_en; raise -> accept next cycle.
//  Drop key_mem_full after round 30 -> key_abort pulse 1 cycle, IDLE, no out_valid; next block correct.
//  out_ready held low 50 cycles in DONE -> out_valid/out_block stable; then 3 back-to-back blocks
//   with out_ready=1 -> outputs match model, 146-cycle spacing.
//  Assert rst in WAIT round 10 -> all outputs at reset values next cycle; new block encrypts correctly.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : simon_pkg                                                    |
// | Description : Shared types, sizes and the Simon round function for the     |
// |               Simon128/256 encrypt datapath.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package simon_pkg;

    // Simon128/256 geometry
    localparam int SIMON_WORD_W = 64;
    localparam int SIMON_ROUNDS = 72;
    localparam int SIMON_KEY_AW = 9;

    typedef logic [SIMON_WORD_W-1:0] simon_word_t;

    typedef struct packed {
        simon_word_t x;
        simon_word_t y;
    } simon_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } eng_state_t;

    // f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x); pure bit permutation and logic, no carries
    function automatic simon_word_t simon_f(input simon_word_t v);
        simon_word_t w_rol1;
        simon_word_t w_rol2;
        simon_word_t w_rol8;
        w_rol1 = {v[SIMON_WORD_W-2:0], v[SIMON_WORD_W-1]};
        w_rol2 = {v[SIMON_WORD_W-3:0], v[SIMON_WORD_W-1 -: 2]};
        w_rol8 = {v[SIMON_WORD_W-9:0], v[SIMON_WORD_W-1 -: 8]};
        return (w_rol1 & w_rol8) ^ w_rol2;
    endfunction

endpackage : simon_pkg
`default_nettype wire

// File: rtl/simon_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : simon_round                                                  |
// | Description : One combinational Simon Feistel round:                       |
// |               x' = y ^ f(x) ^ k,  y' = x.                                  |
// |               Kept separate so a decrypt engine can reuse it.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module simon_round
    import simon_pkg::*;
#(
    parameter int WORD_WIDTH = SIMON_WORD_W
) (
    input  logic [WORD_WIDTH-1:0] i_x,
    input  logic [WORD_WIDTH-1:0] i_y,
    input  logic [WORD_WIDTH-1:0] i_k,
    output logic [WORD_WIDTH-1:0] o_x,
    output logic [WORD_WIDTH-1:0] o_y
);

    logic [WORD_WIDTH-1:0] w_f;

    // The packaged function covers the native 64-bit word; other widths use
    // the same rotation network written against WORD_WIDTH.
    generate
        if (WORD_WIDTH == SIMON_WORD_W) begin : g_pkg_f
            assign w_f = simon_f(i_x);
        end else begin : g_generic_f
            logic [WORD_WIDTH-1:0] w_rol1;
            logic [WORD_WIDTH-1:0] w_rol2;
            logic [WORD_WIDTH-1:0] w_rol8;
            assign w_rol1 = {i_x[WORD_WIDTH-2:0], i_x[WORD_WIDTH-1]};
            assign w_rol2 = {i_x[WORD_WIDTH-3:0], i_x[WORD_WIDTH-1 -: 2]};
            assign w_rol8 = {i_x[WORD_WIDTH-9:0], i_x[WORD_WIDTH-1 -: 8]};
            assign w_f    = (w_rol1 & w_rol8) ^ w_rol2;
        end
    endgenerate

    // Feistel swap: new x mixes in the key, old x becomes new y
    assign o_x = i_y ^ w_f ^ i_k;
    assign o_y = i_x;

endmodule : simon_round
`default_nettype wire

// File: rtl/simon_round_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : simon_round_engine                                           |
// | Description : Iterative Simon128/256 encryption engine. Accepts one        |
// |               plaintext block, fetches round keys 0..NUM_ROUNDS-1 from the |
// |               key memory one at a time, applies one round per key and      |
// |               presents the ciphertext until the consumer takes it.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module simon_round_engine
    import simon_pkg::*;
#(
    parameter int                        WORD_WIDTH     = SIMON_WORD_W,
    parameter int                        NUM_ROUNDS     = SIMON_ROUNDS,
    parameter int                        KEY_ADDR_WIDTH = SIMON_KEY_AW,
    parameter logic [KEY_ADDR_WIDTH-1:0] KEY_BASE       = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_mem_full,
    output logic [KEY_ADDR_WIDTH-1:0]   key_addr,
    output logic                        key_rd_en,
    input  logic [WORD_WIDTH-1:0]       key_data,
    input  logic                        key_data_vld,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*WORD_WIDTH-1:0]     in_block,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WORD_WIDTH-1:0]     out_block,
    output logic                        key_abort
);

    // Round counter is 7 bits wide and stops at the last round, never wrapping
    localparam int                   c_round_w    = 7;
    localparam logic [c_round_w-1:0] c_last_round = c_round_w'(NUM_ROUNDS - 1);

    eng_state_t                  r_state;
    logic [c_round_w-1:0]        r_round;
    logic [WORD_WIDTH-1:0]       r_x;
    logic [WORD_WIDTH-1:0]       r_y;
    logic [KEY_ADDR_WIDTH-1:0]   r_key_addr;
    logic                        r_key_rd_en;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [2*WORD_WIDTH-1:0]     r_out_block;
    logic                        r_key_abort;

    logic [WORD_WIDTH-1:0]       w_x_next;
    logic [WORD_WIDTH-1:0]       w_y_next;
    logic [c_round_w-1:0]        w_round_inc;

    assign w_round_inc = r_round + c_round_w'(1);

    // Single shared round datapath, keyed directly from the memory read data
    simon_round #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_round (
        .i_x (r_x),
        .i_y (r_y),
        .i_k (key_data),
        .o_x (w_x_next),
        .o_y (w_y_next)
    );

    // Control FSM, round counter, state words and all registered outputs.
    // key_rd_en and key_addr are loaded on the edge that enters FETCH so the
    // strobe is high for exactly the FETCH cycle. in_ready is registered: it
    // is only ever raised on the edge that lands (or stays) in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_round     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_key_addr  <= KEY_BASE;
            r_key_rd_en <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_key_abort <= 1'b0;
        end else begin
            r_key_rd_en <= 1'b0;
            r_key_abort <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x         <= in_block[2*WORD_WIDTH-1:WORD_WIDTH];
                        r_y         <= in_block[WORD_WIDTH-1:0];
                        r_round     <= '0;
                        r_key_addr  <= KEY_BASE;
                        r_key_rd_en <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= FETCH;
                    end else begin
                        r_in_ready  <= key_mem_full;
                    end
                end

                FETCH: begin
                    if (!key_mem_full) begin
                        // key set invalidated mid-block: drop the operation
                        r_key_abort <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (!key_mem_full) begin
                        r_key_abort <= 1'b1;
                        r_state     <= IDLE;
                    end else if (key_data_vld) begin
                        r_x <= w_x_next;
                        r_y <= w_y_next;
                        if (r_round == c_last_round) begin
                            r_out_block <= {w_x_next, w_y_next};
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_round     <= w_round_inc;
                            r_key_addr  <= KEY_BASE + KEY_ADDR_WIDTH'(w_round_inc);
                            r_key_rd_en <= 1'b1;
                            r_state     <= FETCH;
                        end
                    end
                end

                DONE: begin
                    // ciphertext is delivered even if the key set goes away now
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= key_mem_full;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign key_addr  = r_key_addr;
    assign key_rd_en = r_key_rd_en;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;
    assign key_abort = r_key_abort;

endmodule : simon_round_engine
`default_nettype wire
